// File: rtl/ddr_burst_responder_pkg.sv
// Shared state codes and address scaling for the DDR burst responder.
package ddr_burst_responder_pkg;

  localparam logic [3:0] IDLE                 = 4'd0;
  localparam logic [3:0] MEM_READ_DATA        = 4'd2;
  localparam logic [3:0] MEM_WRITE_DATA_STORE = 4'd9;
  localparam logic [3:0] DONE                 = 4'd10;

  // Cache addresses are byte-ish (x8); memory addresses are words.
  localparam int unsigned ADDR_SCALE       = 8;
  localparam int unsigned ADDR_SCALE_SHIFT = $clog2(ADDR_SCALE);

  typedef enum logic [3:0] {
    StIdle  = IDLE,
    StRead  = MEM_READ_DATA,
    StWrite = MEM_WRITE_DATA_STORE,
    StDone  = DONE
  } state_e;

  typedef enum logic [1:0] {WrReq, WrCap, WrCmd} wr_phase_e;

endpackage

// File: rtl/ddr_cmd_issuer.sv
// Single-command valid/rdy holding register with a post-accept address incrementer.
module ddr_cmd_issuer #(
  parameter int unsigned AddrWidth = 28,
  parameter int unsigned DataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [AddrWidth-1:0] load_addr,
  input  logic                 issue,
  input  logic                 issue_we,
  input  logic [DataWidth-1:0] issue_wdata,
  input  logic                 abort,
  input  logic                 mem_cmd_rdy,
  output logic                 can_issue,
  output logic                 accepted,
  output logic                 mem_cmd_valid,
  output logic                 mem_cmd_we,
  output logic [AddrWidth-1:0] mem_cmd_addr,
  output logic [DataWidth-1:0] mem_wdata
);

  logic                 valid_q, valid_d;
  logic                 we_q, we_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;

  assign accepted  = valid_q && mem_cmd_rdy;
  // A new command may launch in the same cycle the current one is taken.
  assign can_issue = !valid_q || accepted;

  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (load) begin
      addr_d = load_addr;
    end else if (accepted) begin
      addr_d = addr_q + AddrWidth'(1);
    end
    if (accepted) begin
      valid_d = 1'b0;
    end
    if (issue && can_issue) begin
      valid_d = 1'b1;
      we_d    = issue_we;
      if (issue_we) begin
        wdata_d = issue_wdata;
      end
    end
    if (abort) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_cmd_valid = valid_q;
  assign mem_cmd_we    = we_q;
  assign mem_cmd_addr  = addr_q;
  assign mem_wdata     = wdata_q;

endmodule

// File: rtl/ddr_burst_responder.sv
// Burst responder turning cache load/store bursts into single-word memory commands.
// Optional watchdog enabled by defining MEM_IF_TIMEOUT_EN.
module ddr_burst_responder
  import ddr_burst_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      DATA_read_req,
  input  logic                      DATA_store_req,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
  input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
  output logic [DATA_WIDTH-1:0]     DATA_to_cache,
  output logic [9:0]                rd_cnt_data,
  output logic                      rd_burst_data_valid,
  output logic                      wr_burst_data_req,
  output logic [3:0]                state_interface_module,
  output logic                      mem_cmd_valid,
  input  logic                      mem_cmd_rdy,
  output logic                      mem_cmd_we,
  output logic [DDR_ADDR_WIDTH-1:0] mem_cmd_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_rdata_valid,
  output logic                      err
);

  localparam int unsigned     CntW      = $clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0] BurstLen  = CntW'(BURST_LEN);
  localparam logic [CntW-1:0] BurstLast = CntW'(BURST_LEN - 1);
  localparam logic [9:0]      RdCntEnd  = 10'(BURST_LEN + 1);

  state_e                  state_q, state_d;
  wr_phase_e               wr_q, wr_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [9:0]              rd_cnt_q, rd_cnt_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    load, issue, issue_we, abort, can_issue, accepted, timeout;
  logic [DDR_ADDR_WIDTH-1:0] load_addr;

  ddr_cmd_issuer #(
    .AddrWidth(DDR_ADDR_WIDTH),
    .DataWidth(DATA_WIDTH)
  ) u_issuer (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .load_addr    (load_addr),
    .issue        (issue),
    .issue_we     (issue_we),
    .issue_wdata  (DATA_to_ddr),
    .abort        (abort),
    .mem_cmd_rdy  (mem_cmd_rdy),
    .can_issue    (can_issue),
    .accepted     (accepted),
    .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_we   (mem_cmd_we),
    .mem_cmd_addr (mem_cmd_addr),
    .mem_wdata    (mem_wdata)
  );

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    rd_cnt_d   = rd_cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    load       = 1'b0;
    load_addr  = DATA_read_addr >> ADDR_SCALE_SHIFT;
    issue      = 1'b0;
    issue_we   = 1'b0;
    abort      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Store wins so a dirty line is written back before it is reloaded.
        if (DATA_store_req) begin
          state_d   = StWrite;
          wr_d      = WrReq;
          cnt_d     = '0;
          load      = 1'b1;
          load_addr = DATA_write_addr >> ADDR_SCALE_SHIFT;
        end else if (DATA_read_req) begin
          state_d  = StRead;
          cnt_d    = '0;
          rd_cnt_d = 10'd1;
          load     = 1'b1;
        end
      end
      StRead: begin
        issue = (cnt_q != BurstLen);
        if (issue && can_issue) begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (mem_rdata_valid) begin
          rd_data_d  = mem_rdata;
          rd_valid_d = 1'b1;
          rd_cnt_d   = rd_cnt_q + 10'd1;
          if (rd_cnt_q == 10'(BURST_LEN)) begin
            state_d = StDone;
          end
        end
      end
      StWrite: begin
        unique case (wr_q)
          WrReq: wr_d = WrCap;
          WrCap: begin
            issue    = 1'b1;
            issue_we = 1'b1;
            wr_d     = WrCmd;
          end
          WrCmd: begin
            if (accepted) begin
              cnt_d = cnt_q + CntW'(1);
              wr_d  = WrReq;
              if (cnt_q == BurstLast) begin
                state_d = StDone;
              end
            end
          end
          default: wr_d = WrReq;
        endcase
      end
      StDone: begin
        if (!DATA_read_req && !DATA_store_req) begin
          state_d  = StIdle;
          rd_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (timeout) begin
      state_d  = StDone;
      abort    = 1'b1;
      rd_cnt_d = RdCntEnd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      wr_q       <= WrReq;
      cnt_q      <= '0;
      rd_cnt_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef MEM_IF_TIMEOUT_EN
  localparam int unsigned   WdW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_q;
  logic           err_q, busy, progress;

  assign busy     = (state_q == StRead) || (state_q == StWrite);
  assign progress = accepted || ((state_q == StRead) && mem_rdata_valid);
  assign timeout  = busy && !progress && (wd_q == WdLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!busy || progress || timeout) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + WdW'(1);
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout        = 1'b0;
  assign err            = 1'b0;
`endif

  assign DATA_to_cache          = rd_data_q;
  assign rd_cnt_data            = rd_cnt_q;
  assign rd_burst_data_valid    = rd_valid_q;
  assign wr_burst_data_req      = (state_q == StWrite) && (wr_q == WrReq);
  assign state_interface_module = state_q;

endmodule
